// File: rtl/puf_crp_engine.sv
// PUF challenge/response initiator: LFSR challenges in, packed response word out.
// Define PUF_MAJORITY_EN to evaluate each challenge three times with a majority vote.
module puf_crp_engine #(
   parameter int unsigned N             = 128,
   parameter int unsigned R             = 32,
   parameter int unsigned EXCITE_CYCLES = 1024,
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter logic [N-1:0] TAPS         = 128'hA000_0014_0000_0000_0000_0000_0000_0000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] seed,
   output logic         busy,
   output logic [N-1:0] puf_sel,
   output logic         puf_in,
   output logic         puf_reset,
   input  logic         puf_out,
   output logic [R-1:0] resp_data,
   output logic         resp_valid,
   input  logic         resp_ready
);

   localparam int unsigned KW = (R > 1) ? $clog2(R) : 1;
   localparam logic [15:0] EXC_LAST = 16'(EXCITE_CYCLES - 1);
   localparam logic [15:0] SET_LAST = 16'(SETTLE_CYCLES - 1);
   localparam logic [KW-1:0] K_LAST = KW'(R - 1);
   localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_EXCITE, S_SETTLE, S_SAMPLE, S_DONE
   } state_e;

   state_e        state_q, state_d;
   logic [N-1:0]  chal_q, chal_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [KW-1:0] k_q, k_d;
   logic [R-1:0]  resp_data_q, resp_data_d;
   logic          resp_valid_q, resp_valid_d;
   logic          busy_q, busy_d;
   logic [N-1:0]  puf_sel_q, puf_sel_d;
   logic          puf_in_q, puf_in_d;
   logic          puf_reset_q, puf_reset_d;
   logic          last_eval;
   logic          sample_bit;

`ifdef PUF_MAJORITY_EN
   logic [1:0] ev_q, ev_d;
   logic [1:0] vote_q, vote_d;

   assign last_eval  = (ev_q == 2'd2);
   assign sample_bit = (vote_q[0] & vote_q[1]) |
                       (vote_q[0] & puf_out) |
                       (vote_q[1] & puf_out);
`else
   assign last_eval  = 1'b1;
   assign sample_bit = puf_out;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         chal_q       <= '0;
         cnt_q        <= '0;
         k_q          <= '0;
         resp_data_q  <= '0;
         resp_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         puf_sel_q    <= '0;
         puf_in_q     <= 1'b0;
         puf_reset_q  <= 1'b1;
`ifdef PUF_MAJORITY_EN
         ev_q         <= '0;
         vote_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         chal_q       <= chal_d;
         cnt_q        <= cnt_d;
         k_q          <= k_d;
         resp_data_q  <= resp_data_d;
         resp_valid_q <= resp_valid_d;
         busy_q       <= busy_d;
         puf_sel_q    <= puf_sel_d;
         puf_in_q     <= puf_in_d;
         puf_reset_q  <= puf_reset_d;
`ifdef PUF_MAJORITY_EN
         ev_q         <= ev_d;
         vote_q       <= vote_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      chal_d  = chal_q;
      cnt_d   = cnt_q;
      k_d     = k_q;
`ifdef PUF_MAJORITY_EN
      ev_d    = ev_q;
      vote_d  = vote_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               chal_d  = (seed == '0) ? ONE : seed;
               k_d     = '0;
               state_d = S_LOAD;
`ifdef PUF_MAJORITY_EN
               ev_d    = '0;
`endif
            end
         end
         S_LOAD: begin
            cnt_d   = EXC_LAST;
            state_d = S_EXCITE;
         end
         S_EXCITE: begin
            if (cnt_q == '0) begin
               cnt_d   = SET_LAST;
               state_d = S_SETTLE;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         S_SETTLE: begin
            if (cnt_q == '0) state_d = S_SAMPLE;
            else             cnt_d   = cnt_q - 16'd1;
         end
         S_SAMPLE: begin
            if (!last_eval) begin
`ifdef PUF_MAJORITY_EN
               vote_d[ev_q[0]] = puf_out;
               ev_d            = ev_q + 2'd1;
`endif
               state_d = S_LOAD;
            end else begin
`ifdef PUF_MAJORITY_EN
               ev_d   = '0;
`endif
               chal_d = {chal_q[N-2:0], ^(chal_q & TAPS)};
               if (k_q == K_LAST) begin
                  state_d = S_DONE;
               end else begin
                  k_d     = k_q + 1'b1;
                  state_d = S_LOAD;
               end
            end
         end
         S_DONE: begin
            if (resp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they line up with it once registered.
   always_comb begin
      busy_d       = (state_d != S_IDLE);
      puf_in_d     = (state_d == S_EXCITE);
      puf_reset_d  = (state_d == S_IDLE) || (state_d == S_LOAD) ||
                     (state_d == S_DONE);
      resp_valid_d = (state_d == S_DONE);
      puf_sel_d    = (state_d == S_LOAD) ? chal_d : puf_sel_q;
      resp_data_d  = resp_data_q;
      if (state_q == S_SAMPLE && last_eval) resp_data_d[k_q] = sample_bit;
   end

   assign busy       = busy_q;
   assign puf_sel    = puf_sel_q;
   assign puf_in     = puf_in_q;
   assign puf_reset  = puf_reset_q;
   assign resp_data  = resp_data_q;
   assign resp_valid = resp_valid_q;

endmodule

// File: tb/tb_puf_crp_engine.sv
// Scoreboard bench for puf_crp_engine: random seeds against a challenge/response model.
// Build with PUF_MAJORITY_EN to also exercise the three-way vote.
module tb_puf_crp_engine;

   localparam int N = 8;
   localparam int R = 4;
   localparam int E = 4;
   localparam int S = 2;
   localparam logic [7:0] TAPS = 8'hB8;
`ifdef PUF_MAJORITY_EN
   localparam int EV = 3;
`else
   localparam int EV = 1;
`endif
   localparam int LAT = R * EV * (2 + E + S);

   logic         clk = 1'b0;
   logic         reset, start, puf_out, resp_ready;
   logic [N-1:0] seed;
   logic         busy, puf_in, puf_reset, resp_valid;
   logic [N-1:0] puf_sel;
   logic [R-1:0] resp_data;

   int errs = 0;
   int chks = 0;
   int cyc = 0;
   int start_cyc = 0;
   int rise_cnt = 0;
   bit glitch_en = 1'b0;
   bit maj_mode = 1'b0;
   bit rnd_bit = 1'b0;
   logic [2:0] pat [4];
   logic [N-1:0] chal_exp [$];
   logic [R-1:0] data_exp [$];

   puf_crp_engine #(
      .N(N), .R(R), .EXCITE_CYCLES(E), .SETTLE_CYCLES(S), .TAPS(TAPS)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .seed(seed),
      .busy(busy), .puf_sel(puf_sel), .puf_in(puf_in),
      .puf_reset(puf_reset), .puf_out(puf_out),
      .resp_data(resp_data), .resp_valid(resp_valid),
      .resp_ready(resp_ready)
   );

   always #5 clk = ~clk;

   always @(negedge clk) rnd_bit <= 1'($urandom);

   // PUF model; glitches outside the sample window must not matter.
   always_comb begin
      int r;
      r = (rise_cnt > 0) ? rise_cnt - 1 : 0;
      puf_out = |(puf_sel & 8'h0A);
      if (maj_mode) puf_out = pat[(r / 3) % 4][r % 3];
      else if (glitch_en && (puf_in || puf_reset)) puf_out = rnd_bit;
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!reset && start && !busy) start_cyc <= cyc;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      chks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Reference: walk the challenge sequence and evaluate the PUF per challenge.
   task automatic expect_run(input logic [N-1:0] s);
      logic [N-1:0] c;
      logic [R-1:0] d;
      c = (s == 0) ? 8'h01 : s;
      d = '0;
      for (int k = 0; k < R; k++) begin
         for (int e = 0; e < EV; e++) chal_exp.push_back(c);
         if (maj_mode) d[k] = ($countones(pat[k]) >= 2);
         else          d[k] = |(c & 8'h0A);
         c = {c[N-2:0], ^(c & TAPS)};
      end
      data_exp.push_back(d);
   endtask

   // Monitor
   initial begin
      bit pin = 0, pvld = 0;
      int hi = 0, lo = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            hi = 0; lo = 0; pin = 0; pvld = 0;
         end else begin
            if (puf_in && !pin) begin
               rise_cnt++;
               if (chal_exp.size() == 0) begin
                  chks++; errs++;
                  $display("FAIL challenge: unexpected sel %0h", puf_sel);
               end else chk("challenge", puf_sel, chal_exp.pop_front());
            end
            if (puf_in) hi++;
            else if (hi > 0) begin chk("excite_len", hi, E); hi = 0; end
            if (!puf_reset) lo++;
            else if (lo > 0) begin chk("reset_low_len", lo, E + S + 1); lo = 0; end
            if (resp_valid && !pvld) begin
               if (data_exp.size() == 0) begin
                  chks++; errs++;
                  $display("FAIL resp: unexpected word %0h", resp_data);
               end else chk("resp_data", resp_data, data_exp.pop_front());
               chk("latency", cyc - start_cyc - 1, LAT);
            end
            pin = puf_in; pvld = resp_valid;
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic run(input logic [N-1:0] s, input int hold, input bit poke);
      int n;
      logic [R-1:0] d;
      expect_run(s);
      rise_cnt = 0;
      seed = s; start = 1'b1; tick(); start = 1'b0; seed = 8'($urandom);
      n = 0;
      while (!resp_valid && n < LAT + 20) begin
         start = poke && ($urandom_range(0, 7) == 0);
         tick(); n++;
      end
      start = 1'b0;
      if (!resp_valid) begin
         chks++; errs++;
         $display("FAIL timeout: no resp_valid after %0d cycles, want %0d", n, LAT);
         return;
      end
      chk("busy_done", busy, 1);
      d = resp_data;
      repeat (hold) begin
         start = 1'($urandom);
         tick();
         chk("hold_valid", resp_valid, 1);
         chk("hold_data", resp_data, d);
         chk("hold_busy", busy, 1);
      end
      start = 1'b0; resp_ready = 1'b1; tick(); resp_ready = 1'b0;
      chk("idle_busy", busy, 0);
      chk("idle_valid", resp_valid, 0);
   endtask

   initial begin
      int n;
      reset = 1'b1; start = 1'b0; seed = '0; resp_ready = 1'b0;
      pat[0] = 3'b101; pat[1] = 3'b100; pat[2] = 3'b111; pat[3] = 3'b001;
      repeat (3) tick();
      reset = 1'b0; tick();
      chk("rst_puf_reset", puf_reset, 1);
      chk("rst_busy", busy, 0);
      chk("rst_valid", resp_valid, 0);
      chk("rst_sel", puf_sel, 0);
      chk("rst_in", puf_in, 0);
      chk("rst_data", resp_data, 0);

      run(8'h01, 10, 1'b1);
      run(8'h00, 2, 1'b0);

      // Abort during the second challenge's excitation
      expect_run(8'h01);
      rise_cnt = 0;
      seed = 8'h01; start = 1'b1; tick(); start = 1'b0;
      n = 0;
      while (!(puf_in && rise_cnt > EV) && n < LAT) begin tick(); n++; end
      if (!puf_in) begin
         chks++; errs++;
         $display("FAIL abort_wait: puf_in %0b want 1", puf_in);
      end
      reset = 1'b1;
      chal_exp.delete(); data_exp.delete();
      tick(); reset = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_puf_reset", puf_reset, 1);
      chk("abort_in", puf_in, 0);
      chk("abort_data", resp_data, 0);
      chk("abort_valid", resp_valid, 0);
      chk("abort_sel", puf_sel, 0);
      tick();
      run(8'h08, 1, 1'b0);

      glitch_en = 1'b1;
      repeat (6) run(8'($urandom), $urandom_range(0, 4), 1'b1);
      glitch_en = 1'b0;

`ifdef PUF_MAJORITY_EN
      maj_mode = 1'b1;
      run(8'h5A, 1, 1'b0);
      maj_mode = 1'b0;
`endif

      repeat (3) tick();
      if (chal_exp.size() != 0 || data_exp.size() != 0) begin
         chks++; errs++;
         $display("FAIL leftover: %0d challenges %0d words pending",
                  chal_exp.size(), data_exp.size());
      end
      $display("Result: errors=%0d of %0d checks", errs, chks);
      $finish;
   end

endmodule
